// File: rtl/bcam_writer.sv
// bcam_writer: write-side controller for a binary CAM.
//
// Accepts INSERT / DELETE / CLEAR commands, keeps a valid bitmap of the table,
// checks INSERT keys for duplicates through the CAM match port, allocates the
// lowest free entry and drives the CAM write port. Free entries hold the
// all-ones EMPTY sentinel; a full sweep writes EMPTY everywhere after reset
// and on CLEAR.
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   cmd_valid/cmd_ready         command handshake (cmd_op, cmd_key, cmd_addr)
//   rsp_valid/rsp_ready         response handshake (rsp_status, rsp_addr)
//   cam_match_en, cam_key       search request to the CAM
//   cam_match, cam_match_addr   registered search result (index plus one)
//   cam_wr_en/addr/data         single-cycle CAM write strobe
//   occupancy                   number of valid entries

module bcam_writer #(
    parameter int unsigned MEMLEN   = 32,
    parameter int unsigned MEMDEPTH = 512,
    parameter int unsigned MEMDBITS = 9
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [MEMLEN-1:0]   cmd_key,
    input  logic [MEMDBITS-1:0] cmd_addr,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [1:0]          rsp_status,
    output logic [MEMDBITS-1:0] rsp_addr,
    output logic                cam_match_en,
    output logic [MEMLEN-1:0]   cam_key,
    input  logic                cam_match,
    input  logic [MEMDBITS-1:0] cam_match_addr,
    output logic                cam_wr_en,
    output logic [MEMDBITS-1:0] cam_wr_addr,
    output logic [MEMLEN-1:0]   cam_wr_data,
    output logic [MEMDBITS:0]   occupancy
);

    localparam logic [MEMLEN-1:0]   EMPTY   = '1;
    localparam logic [MEMDBITS:0]   DEPTH_W = (MEMDBITS+1)'(MEMDEPTH);
    localparam logic [MEMDBITS-1:0] LAST    = MEMDBITS'(MEMDEPTH - 1);

    localparam logic [1:0] OpInsert = 2'b00;
    localparam logic [1:0] OpDelete = 2'b01;
    localparam logic [1:0] OpClear  = 2'b10;

    localparam logic [1:0] RspOk      = 2'b00;
    localparam logic [1:0] RspDup     = 2'b01;
    localparam logic [1:0] RspFull    = 2'b10;
    localparam logic [1:0] RspInvalid = 2'b11;

    typedef enum logic [2:0] {
        StClear, StIdle, StLookup, StWait, StScan, StWrite, StResp
    } state_e;

    state_e                state_q, state_d;
    logic [MEMDBITS-1:0]   idx_q, idx_d;
    logic [MEMDEPTH-1:0]   bitmap_q, bitmap_d;
    logic [MEMDBITS:0]     occ_q, occ_d;
    logic [1:0]            op_q, op_d;
    logic [MEMLEN-1:0]     key_q, key_d;
    // go_q gates the sweep so that no write is issued while reset is held
    // (reset parks the FSM in StClear); it arms one cycle after release.
    logic                  go_q, go_d;
    logic                  clr_cmd_q, clr_cmd_d;
    logic [1:0]            rsp_status_q, rsp_status_d;
    logic [MEMDBITS-1:0]   rsp_addr_q, rsp_addr_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StClear;
            idx_q        <= '0;
            bitmap_q     <= '0;
            occ_q        <= '0;
            op_q         <= OpInsert;
            key_q        <= '0;
            go_q         <= 1'b0;
            clr_cmd_q    <= 1'b0;
            rsp_status_q <= RspOk;
            rsp_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            bitmap_q     <= bitmap_d;
            occ_q        <= occ_d;
            op_q         <= op_d;
            key_q        <= key_d;
            go_q         <= go_d;
            clr_cmd_q    <= clr_cmd_d;
            rsp_status_q <= rsp_status_d;
            rsp_addr_q   <= rsp_addr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        bitmap_d     = bitmap_q;
        occ_d        = occ_q;
        op_d         = op_q;
        key_d        = key_q;
        go_d         = go_q;
        clr_cmd_d    = clr_cmd_q;
        rsp_status_d = rsp_status_q;
        rsp_addr_d   = rsp_addr_q;

        unique case (state_q)
            StClear: begin
                bitmap_d = '0;
                occ_d    = '0;
                if (!go_q) begin
                    go_d = 1'b1;
                end else if (idx_q == LAST) begin
                    go_d      = 1'b0;
                    idx_d     = '0;
                    clr_cmd_d = 1'b0;
                    if (clr_cmd_q) begin
                        rsp_status_d = RspOk;
                        rsp_addr_d   = '0;
                        state_d      = StResp;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    idx_d = idx_q + MEMDBITS'(1);
                end
            end

            StIdle: begin
                if (cmd_valid) begin
                    op_d = cmd_op;
                    unique case (cmd_op)
                        OpInsert: begin
                            key_d = cmd_key;
                            if (cmd_key == EMPTY) begin
                                rsp_status_d = RspInvalid;
                                rsp_addr_d   = '0;
                                state_d      = StResp;
                            end else begin
                                state_d = StLookup;
                            end
                        end
                        OpDelete: begin
                            if (({1'b0, cmd_addr} < DEPTH_W) && bitmap_q[cmd_addr]) begin
                                idx_d   = cmd_addr;
                                state_d = StWrite;
                            end else begin
                                rsp_status_d = RspInvalid;
                                rsp_addr_d   = cmd_addr;
                                state_d      = StResp;
                            end
                        end
                        OpClear: begin
                            idx_d     = '0;
                            go_d      = 1'b1;
                            clr_cmd_d = 1'b1;
                            state_d   = StClear;
                        end
                        default: begin
                            rsp_status_d = RspInvalid;
                            rsp_addr_d   = cmd_addr;
                            state_d      = StResp;
                        end
                    endcase
                end
            end

            StLookup: state_d = StWait;

            StWait: begin
                if (cam_match) begin
                    // CAM reports index plus one so that zero never looks like a hit.
                    rsp_status_d = RspDup;
                    rsp_addr_d   = cam_match_addr - MEMDBITS'(1);
                    state_d      = StResp;
                end else if (occ_q == DEPTH_W) begin
                    rsp_status_d = RspFull;
                    rsp_addr_d   = '0;
                    state_d      = StResp;
                end else begin
                    idx_d   = '0;
                    state_d = StScan;
                end
            end

            StScan: begin
                if (!bitmap_q[idx_q]) begin
                    state_d = StWrite;
                end else if (idx_q == LAST) begin
                    // Unreachable while occupancy tracks the bitmap; fail safe.
                    rsp_status_d = RspFull;
                    rsp_addr_d   = '0;
                    state_d      = StResp;
                end else begin
                    idx_d = idx_q + MEMDBITS'(1);
                end
            end

            StWrite: begin
                if (op_q == OpDelete) begin
                    bitmap_d[idx_q] = 1'b0;
                    if (occ_q != '0) occ_d = occ_q - (MEMDBITS+1)'(1);
                end else begin
                    bitmap_d[idx_q] = 1'b1;
                    if (occ_q != DEPTH_W) occ_d = occ_q + (MEMDBITS+1)'(1);
                end
                rsp_status_d = RspOk;
                rsp_addr_d   = idx_q;
                state_d      = StResp;
            end

            StResp: begin
                if (rsp_ready) state_d = StIdle;
            end

            default: begin
                idx_d   = '0;
                go_d    = 1'b0;
                state_d = StClear;
            end
        endcase
    end

    assign cmd_ready    = (state_q == StIdle);
    assign rsp_valid    = (state_q == StResp);
    assign rsp_status   = rsp_status_q;
    assign rsp_addr     = rsp_addr_q;
    assign cam_match_en = (state_q == StLookup);
    assign cam_key      = key_q;
    assign occupancy    = occ_q;

    assign cam_wr_en   = (state_q == StWrite) || ((state_q == StClear) && go_q);
    assign cam_wr_addr = cam_wr_en ? idx_q : '0;
    assign cam_wr_data = !cam_wr_en ? '0 :
                         ((state_q == StWrite) && (op_q == OpInsert)) ? key_q : EMPTY;

endmodule

// File: tb/tb_bcam_writer.sv
// Directed bench for bcam_writer with a small behavioural CAM (8 x 32).
module tb_bcam_writer;

    localparam int W = 32;
    localparam int D = 8;
    localparam int B = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         cmd_valid, cmd_ready;
    logic [1:0]   cmd_op;
    logic [W-1:0] cmd_key;
    logic [B-1:0] cmd_addr;
    logic         rsp_valid, rsp_ready;
    logic [1:0]   rsp_status;
    logic [B-1:0] rsp_addr;
    logic         cam_match_en;
    logic [W-1:0] cam_key;
    logic         cam_match = 1'b0;
    logic [B-1:0] cam_match_addr = '0;
    logic         cam_wr_en;
    logic [B-1:0] cam_wr_addr;
    logic [W-1:0] cam_wr_data;
    logic [B:0]   occupancy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bcam_writer #(.MEMLEN(W), .MEMDEPTH(D), .MEMDBITS(B)) dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_key        (cmd_key),
        .cmd_addr       (cmd_addr),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_status     (rsp_status),
        .rsp_addr       (rsp_addr),
        .cam_match_en   (cam_match_en),
        .cam_key        (cam_key),
        .cam_match      (cam_match),
        .cam_match_addr (cam_match_addr),
        .cam_wr_en      (cam_wr_en),
        .cam_wr_addr    (cam_wr_addr),
        .cam_wr_data    (cam_wr_data),
        .occupancy      (occupancy)
    );

    // Behavioural CAM: registered lowest-index match, reported as index + 1.
    logic [W-1:0] cam_mem [D];
    always @(posedge clk) begin
        logic         hit;
        logic [B-1:0] hidx;
        hit  = 1'b0;
        hidx = '0;
        if (cam_wr_en) cam_mem[cam_wr_addr] <= cam_wr_data;
        for (int i = D - 1; i >= 0; i--) begin
            if (cam_mem[i] === cam_key) begin
                hit  = 1'b1;
                hidx = B'(i);
            end
        end
        cam_match      <= cam_match_en && hit;
        cam_match_addr <= (cam_match_en && hit) ? hidx + B'(1) : '0;
    end

    // Write / search monitors.
    int           wr_cnt = 0;
    int           me_cnt = 0;
    logic [B-1:0] wr_addr_log [128];
    logic [W-1:0] wr_data_log [128];
    always @(posedge clk) begin
        if (cam_wr_en) begin
            if (wr_cnt < 128) begin
                wr_addr_log[wr_cnt] <= cam_wr_addr;
                wr_data_log[wr_cnt] <= cam_wr_data;
            end
            wr_cnt <= wr_cnt + 1;
        end
        if (cam_match_en) me_cnt <= me_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready", 64'(cmd_ready), 64'd1);
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [W-1:0] key, input logic [B-1:0] addr);
        wait_ready();
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_key   = key;
        cmd_addr  = addr;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (!rsp_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_valid", 64'(rsp_valid), 64'd1);
    endtask

    task automatic accept();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic txn(input string tag, input logic [1:0] op, input logic [W-1:0] key,
                       input logic [B-1:0] addr, input logic [1:0] exp_st,
                       input logic [B-1:0] exp_addr, input bit chk_addr);
        do_cmd(op, key, addr);
        wait_rsp();
        chk({tag, "_status"}, 64'(rsp_status), 64'(exp_st));
        if (chk_addr) chk({tag, "_addr"}, 64'(rsp_addr), 64'(exp_addr));
        accept();
    endtask

    int wb, mb;

    initial begin
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_key   = '0;
        cmd_addr  = '0;
        rsp_ready = 1'b0;
        reset     = 1'b1;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst_wr_en", 64'(cam_wr_en), 64'd0);
        chk("rst_match_en", 64'(cam_match_en), 64'd0);
        chk("rst_occ", 64'(occupancy), 64'd0);
        chk("rst_wr_data", 64'(cam_wr_data), 64'd0);
        chk("rst_cam_key", 64'(cam_key), 64'd0);

        // Post-reset sweep.
        wb = wr_cnt;
        reset = 1'b0;
        wait_ready();
        chk("sweep_cnt", 64'(wr_cnt - wb), 64'd8);
        for (int i = 0; i < D; i++) begin
            chk("sweep_addr", 64'(wr_addr_log[wb + i]), 64'(i));
            chk("sweep_data", 64'(wr_data_log[wb + i]), 64'hFFFFFFFF);
        end
        chk("sweep_occ", 64'(occupancy), 64'd0);

        // INSERT with CAM miss.
        wb = wr_cnt; mb = me_cnt;
        txn("ins_a", 2'b00, 32'h0000000A, '0, 2'b00, 3'd0, 1'b1);
        chk("ins_a_match_en", 64'(me_cnt - mb), 64'd1);
        chk("ins_a_wr_cnt", 64'(wr_cnt - wb), 64'd1);
        chk("ins_a_wr_addr", 64'(wr_addr_log[wb]), 64'd0);
        chk("ins_a_wr_data", 64'(wr_data_log[wb]), 64'h0000000A);
        chk("ins_a_occ", 64'(occupancy), 64'd1);

        // INSERT of the same key: CAM hits at index 0 (match addr 1).
        wb = wr_cnt; mb = me_cnt;
        txn("dup_a", 2'b00, 32'h0000000A, '0, 2'b01, 3'd0, 1'b1);
        chk("dup_a_match_en", 64'(me_cnt - mb), 64'd1);
        chk("dup_a_wr_cnt", 64'(wr_cnt - wb), 64'd0);
        chk("dup_a_occ", 64'(occupancy), 64'd1);

        // Fill the remaining seven entries.
        for (int i = 1; i < D; i++) begin
            txn("fill", 2'b00, 32'h10 + 32'(i), '0, 2'b00, B'(i), 1'b1);
        end
        chk("fill_occ", 64'(occupancy), 64'd8);

        wb = wr_cnt;
        txn("full", 2'b00, 32'h55, '0, 2'b10, '0, 1'b0);
        chk("full_wr_cnt", 64'(wr_cnt - wb), 64'd0);

        wb = wr_cnt;
        txn("del3", 2'b01, '0, 3'd3, 2'b00, 3'd3, 1'b1);
        chk("del3_wr_cnt", 64'(wr_cnt - wb), 64'd1);
        chk("del3_wr_addr", 64'(wr_addr_log[wb]), 64'd3);
        chk("del3_wr_data", 64'(wr_data_log[wb]), 64'hFFFFFFFF);
        chk("del3_occ", 64'(occupancy), 64'd7);

        txn("ins55", 2'b00, 32'h55, '0, 2'b00, 3'd3, 1'b1);
        chk("ins55_occ", 64'(occupancy), 64'd8);

        // CLEAR command.
        wb = wr_cnt;
        txn("clear", 2'b10, '0, '0, 2'b00, 3'd0, 1'b1);
        chk("clear_wr_cnt", 64'(wr_cnt - wb), 64'd8);
        chk("clear_occ", 64'(occupancy), 64'd0);

        // Invalid cases.
        wb = wr_cnt;
        txn("del5_empty", 2'b01, '0, 3'd5, 2'b11, 3'd5, 1'b1);
        chk("del5_wr_cnt", 64'(wr_cnt - wb), 64'd0);
        mb = me_cnt;
        txn("ins_empty", 2'b00, 32'hFFFFFFFF, '0, 2'b11, '0, 1'b0);
        chk("ins_empty_match_en", 64'(me_cnt - mb), 64'd0);
        txn("op11", 2'b11, '0, 3'd6, 2'b11, 3'd6, 1'b1);

        // Response back-pressure.
        do_cmd(2'b00, 32'h77, '0);
        wait_rsp();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("hold_valid", 64'(rsp_valid), 64'd1);
            chk("hold_status", 64'(rsp_status), 64'd0);
            chk("hold_addr", 64'(rsp_addr), 64'd0);
        end
        accept();
        chk("hold_occ", 64'(occupancy), 64'd1);

        txn("ins21", 2'b00, 32'h21, '0, 2'b00, 3'd1, 1'b1);
        txn("ins22", 2'b00, 32'h22, '0, 2'b00, 3'd2, 1'b1);

        // Reset while scanning (entries 0..2 set, so scan is in progress).
        wb = wr_cnt;
        do_cmd(2'b00, 32'h23, '0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("midrst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("midrst_wr_en", 64'(cam_wr_en), 64'd0);
        chk("midrst_occ", 64'(occupancy), 64'd0);
        chk("midrst_no_write", 64'(wr_cnt - wb), 64'd0);
        repeat (2) @(negedge clk);
        wb = wr_cnt;
        reset = 1'b0;
        wait_ready();
        chk("midrst_sweep_cnt", 64'(wr_cnt - wb), 64'd8);
        chk("midrst_sweep_last", 64'(wr_addr_log[wb + 7]), 64'd7);
        chk("midrst_occ_after", 64'(occupancy), 64'd0);
        txn("ins23", 2'b00, 32'h23, '0, 2'b00, 3'd0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
